// File: rtl/axi_rom_burst_slave_if.sv
// AXI4 read-address and read-data channel bundle for the ROM burst slave.
// A transfer on either channel happens on a rising edge where VALID and READY are both 1; VALID never waits for READY, and payload is held while VALID=1 and READY=0.
interface axi_rom_burst_slave_if #(
    parameter int ID_W   = 8,
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int LEN_W  = 4
);
    logic [ID_W-1:0]   ARID_S;
    logic [ADDR_W-1:0] ARADDR_S;
    logic [LEN_W-1:0]  ARLEN_S;
    logic [2:0]        ARSIZE_S;
    logic [1:0]        ARBURST_S;
    logic              ARVALID_S;
    logic              ARREADY_S;
    logic [ID_W-1:0]   RID_S;
    logic [DATA_W-1:0] RDATA_S;
    logic [1:0]        RRESP_S;
    logic              RLAST_S;
    logic              RVALID_S;
    logic              RREADY_S;

    modport master (
        output ARID_S, ARADDR_S, ARLEN_S, ARSIZE_S, ARBURST_S, ARVALID_S, RREADY_S,
        input  ARREADY_S, RID_S, RDATA_S, RRESP_S, RLAST_S, RVALID_S
    );

    modport slave (
        input  ARID_S, ARADDR_S, ARLEN_S, ARSIZE_S, ARBURST_S, ARVALID_S, RREADY_S,
        output ARREADY_S, RID_S, RDATA_S, RRESP_S, RLAST_S, RVALID_S
    );
endinterface

// File: rtl/axi_rom_burst_slave.sv
// AXI4 read-only burst slave in front of a synchronous ROM with one cycle of read latency.
// Handles INCR/FIXED/WRAP bursts at one beat per cycle and answers illegal requests with SLVERR.
module axi_rom_burst_slave #(
    parameter int ID_W   = 8,
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int ROM_AW = 12,
    parameter int LEN_W  = 4
) (
    input  logic                  ACLK,
    input  logic                  ARESET,
    axi_rom_burst_slave_if.slave  axi,
    input  logic [DATA_W-1:0]     DO,
    output logic                  OE,
    output logic                  CS,
    output logic [ROM_AW-1:0]     A,
    output logic [1:0]            dbg_state_o
);
    localparam int OFF = $clog2(DATA_W / 8);

    typedef enum logic [1:0] {IDLE, FETCH, DATA, ERR} state_e;

    state_e            state_q;
    logic              arready_q;
    logic [ID_W-1:0]   rid_q;
    logic [ROM_AW-1:0] word_q;
    logic [LEN_W-1:0]  cnt_q;
    logic [LEN_W-1:0]  len_q;
    logic [1:0]        burst_q;
    logic [DATA_W-1:0] rdata_q;
    logic              fresh_q;
    logic [1:0]        rresp_q;
    logic              rlast_q;
    logic              rvalid_q;

    logic              ar_hs;
    logic              r_hs;
    logic              ar_legal;
    logic              wrap_len_ok;
    logic [ROM_AW-1:0] ar_word;
    logic [ROM_AW-1:0] wrap_mask;
    logic [ROM_AW-1:0] next_word;
    logic [ROM_AW-1:0] rom_a_d;
    logic              rom_oe_d;
    logic              unused_addr_bits;

    assign ar_hs   = arready_q & axi.ARVALID_S;
    assign r_hs    = rvalid_q & axi.RREADY_S;
    assign ar_word = axi.ARADDR_S[ROM_AW+OFF-1:OFF];
    assign unused_addr_bits = ^{axi.ARADDR_S[ADDR_W-1:ROM_AW+OFF], axi.ARADDR_S[OFF-1:0]};

    // WRAP length must be 2, 4, 8 or 16 beats: ARLEN nonzero and ARLEN+1 a power of two.
    assign wrap_len_ok = (axi.ARLEN_S != '0) &&
                         ((axi.ARLEN_S & (axi.ARLEN_S + LEN_W'(1))) == '0);
    assign ar_legal = (axi.ARSIZE_S == 3'(OFF)) && (axi.ARBURST_S != 2'b11) &&
                      ((axi.ARBURST_S != 2'b10) || wrap_len_ok);

    assign wrap_mask = ROM_AW'(len_q);

    always_comb begin
        next_word = word_q + ROM_AW'(1);
        case (burst_q)
            2'b00:   next_word = word_q;
            2'b10:   next_word = (word_q & ~wrap_mask) | ((word_q + ROM_AW'(1)) & wrap_mask);
            default: next_word = word_q + ROM_AW'(1);
        endcase
    end

    // The next fetch is issued in the same cycle as the accepted beat so the ROM keeps one beat per cycle.
    always_comb begin
        rom_oe_d = 1'b0;
        rom_a_d  = '0;
        if (state_q == FETCH) begin
            rom_oe_d = 1'b1;
            rom_a_d  = word_q;
        end else if ((state_q == DATA) && r_hs && !rlast_q) begin
            rom_oe_d = 1'b1;
            rom_a_d  = next_word;
        end
    end

    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            state_q   <= IDLE;
            arready_q <= 1'b0;
            rid_q     <= '0;
            word_q    <= '0;
            cnt_q     <= '0;
            len_q     <= '0;
            burst_q   <= '0;
            rdata_q   <= '0;
            fresh_q   <= 1'b0;
            rresp_q   <= '0;
            rlast_q   <= 1'b0;
            rvalid_q  <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    arready_q <= 1'b1;
                    fresh_q   <= 1'b0;
                    if (ar_hs) begin
                        arready_q <= 1'b0;
                        rid_q     <= axi.ARID_S;
                        word_q    <= ar_word;
                        cnt_q     <= axi.ARLEN_S;
                        len_q     <= axi.ARLEN_S;
                        burst_q   <= axi.ARBURST_S;
                        if (ar_legal) begin
                            state_q <= FETCH;
                        end else begin
                            state_q  <= ERR;
                            rvalid_q <= 1'b1;
                            rresp_q  <= 2'b10;
                            rdata_q  <= '0;
                            rlast_q  <= (axi.ARLEN_S == '0);
                        end
                    end
                end
                FETCH: begin
                    fresh_q  <= 1'b1;
                    rvalid_q <= 1'b1;
                    rresp_q  <= 2'b00;
                    rlast_q  <= (cnt_q == '0);
                    state_q  <= DATA;
                end
                DATA: begin
                    // DO is only guaranteed for the cycle after a fetch; keep a copy for stalls.
                    fresh_q <= 1'b0;
                    if (fresh_q) rdata_q <= DO;
                    if (r_hs) begin
                        if (rlast_q) begin
                            rvalid_q  <= 1'b0;
                            rlast_q   <= 1'b0;
                            arready_q <= 1'b1;
                            state_q   <= IDLE;
                        end else begin
                            word_q  <= next_word;
                            cnt_q   <= cnt_q - LEN_W'(1);
                            rlast_q <= (cnt_q == LEN_W'(1));
                            fresh_q <= 1'b1;
                        end
                    end
                end
                ERR: begin
                    if (r_hs) begin
                        if (rlast_q) begin
                            rvalid_q  <= 1'b0;
                            rlast_q   <= 1'b0;
                            rresp_q   <= 2'b00;
                            arready_q <= 1'b1;
                            state_q   <= IDLE;
                        end else begin
                            cnt_q   <= cnt_q - LEN_W'(1);
                            rlast_q <= (cnt_q == LEN_W'(1));
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign axi.ARREADY_S = arready_q;
    assign axi.RID_S     = rid_q;
    assign axi.RDATA_S   = fresh_q ? DO : rdata_q;
    assign axi.RRESP_S   = rresp_q;
    assign axi.RLAST_S   = rlast_q;
    assign axi.RVALID_S  = rvalid_q;
    assign OE            = rom_oe_d;
    assign CS            = rom_oe_d;
    assign A             = rom_a_d;
    assign dbg_state_o   = state_q;
endmodule

// File: tb/tb_axi_rom_burst_slave.sv
// Directed bench for axi_rom_burst_slave: behavioural ROM, per-burst expected queue, beat-level checks.
module tb_axi_rom_burst_slave;
    localparam int ID_W   = 8;
    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;
    localparam int ROM_AW = 12;
    localparam int LEN_W  = 4;

    logic              clk;
    logic              rst;
    logic [DATA_W-1:0] rom_do;
    logic              rom_oe;
    logic              rom_cs;
    logic [ROM_AW-1:0] rom_a;
    logic [1:0]        dbg_state;

    int checks;
    int failures;

    logic [DATA_W-1:0] exp_q[$];
    logic [ROM_AW-1:0] exp_a_q[$];
    logic [ROM_AW-1:0] a_q[$];

    axi_rom_burst_slave_if #(.ID_W(ID_W), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .LEN_W(LEN_W)) axi_if ();

    axi_rom_burst_slave #(
        .ID_W(ID_W), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .ROM_AW(ROM_AW), .LEN_W(LEN_W)
    ) dut (
        .ACLK        (clk),
        .ARESET      (rst),
        .axi         (axi_if.slave),
        .DO          (rom_do),
        .OE          (rom_oe),
        .CS          (rom_cs),
        .A           (rom_a),
        .dbg_state_o (dbg_state)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [DATA_W-1:0] rom_word(input logic [ROM_AW-1:0] w);
        return 32'hC0DE_0000 | 32'(w);
    endfunction

    // ROM macro: output register loaded when OE is high, held otherwise
    always @(posedge clk) begin
        if (rom_oe) rom_do <= rom_word(rom_a);
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // driver tasks
    task automatic send_ar(input logic [7:0] id, input logic [31:0] addr, input logic [3:0] len,
                           input logic [2:0] size, input logic [1:0] burst);
        bit got;
        got = 1'b0;
        @(negedge clk);
        axi_if.ARID_S    = id;
        axi_if.ARADDR_S  = addr;
        axi_if.ARLEN_S   = len;
        axi_if.ARSIZE_S  = size;
        axi_if.ARBURST_S = burst;
        axi_if.ARVALID_S = 1'b1;
        for (int i = 0; i < 20; i++) begin
            #1;
            if (axi_if.ARREADY_S) begin
                got = 1'b1;
                break;
            end
            @(negedge clk);
        end
        check("ar_accept", 64'(got), 64'd1);
        @(negedge clk);
        axi_if.ARVALID_S = 1'b0;
    endtask

    task automatic collect(input logic [7:0] id, input logic [1:0] resp, input bit toggle,
                           output int first_cycle);
        bit                stalled;
        logic [DATA_W-1:0] prev_data;
        logic              prev_last;
        logic [DATA_W-1:0] exp;
        int                k;
        first_cycle = -1;
        stalled     = 1'b0;
        prev_data   = '0;
        prev_last   = 1'b0;
        k           = 0;
        for (int cyc = 0; cyc < 200 && exp_q.size() > 0; cyc++) begin
            axi_if.RREADY_S = toggle ? (k % 3 == 0) : 1'b1;
            #1;
            if (rom_oe) a_q.push_back(rom_a);
            if (axi_if.RVALID_S) begin
                if (first_cycle < 0) first_cycle = cyc;
                if (stalled) begin
                    check("stall_rdata", 64'(axi_if.RDATA_S), 64'(prev_data));
                    check("stall_rlast", 64'(axi_if.RLAST_S), 64'(prev_last));
                end
                if (axi_if.RREADY_S) begin
                    exp = exp_q.pop_front();
                    check("rdata", 64'(axi_if.RDATA_S), 64'(exp));
                    check("rresp", 64'(axi_if.RRESP_S), 64'(resp));
                    check("rid", 64'(axi_if.RID_S), 64'(id));
                    check("rlast", 64'(axi_if.RLAST_S), 64'(exp_q.size() == 0));
                    stalled = 1'b0;
                end else begin
                    check("stall_oe", 64'(rom_oe), 64'd0);
                    stalled   = 1'b1;
                    prev_data = axi_if.RDATA_S;
                    prev_last = axi_if.RLAST_S;
                end
                k++;
            end
            @(negedge clk);
        end
        check("beats_left", 64'(exp_q.size()), 64'd0);
        axi_if.RREADY_S = 1'b0;
        #1;
        check("rvalid_after", 64'(axi_if.RVALID_S), 64'd0);
        check("arready_after", 64'(axi_if.ARREADY_S), 64'd1);
    endtask

    task automatic check_addrs(input string tag);
        check({tag, "_count"}, 64'(a_q.size()), 64'(exp_a_q.size()));
        for (int i = 0; i < exp_a_q.size() && i < a_q.size(); i++)
            check(tag, 64'(a_q[i]), 64'(exp_a_q[i]));
    endtask

    task automatic start_burst();
        exp_q.delete();
        exp_a_q.delete();
        a_q.delete();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int first;
        checks   = 0;
        failures = 0;
        rst      = 1'b1;
        rom_do   = '0;
        axi_if.ARID_S    = '0;
        axi_if.ARADDR_S  = '0;
        axi_if.ARLEN_S   = '0;
        axi_if.ARSIZE_S  = '0;
        axi_if.ARBURST_S = '0;
        axi_if.ARVALID_S = 1'b0;
        axi_if.RREADY_S  = 1'b0;

        repeat (3) @(negedge clk);
        check("rst_arready", 64'(axi_if.ARREADY_S), 64'd0);
        check("rst_rvalid", 64'(axi_if.RVALID_S), 64'd0);
        check("rst_rlast", 64'(axi_if.RLAST_S), 64'd0);
        check("rst_rdata", 64'(axi_if.RDATA_S), 64'd0);
        check("rst_rid", 64'(axi_if.RID_S), 64'd0);
        check("rst_rresp", 64'(axi_if.RRESP_S), 64'd0);
        check("rst_oe", 64'(rom_oe), 64'd0);
        check("rst_cs", 64'(rom_cs), 64'd0);
        check("rst_a", 64'(rom_a), 64'd0);
        check("rst_state", 64'(dbg_state), 64'd0);
        rst = 1'b0;
        @(negedge clk);
        check("arready_post_rst", 64'(axi_if.ARREADY_S), 64'd1);

        // single beat, 0x10 -> word 4, cycle-exact latency
        start_burst();
        exp_q.push_back(32'hC0DE_0004);
        exp_a_q.push_back(12'h004);
        send_ar(8'h11, 32'h0000_0010, 4'd0, 3'd2, 2'b01);
        #1;
        check("c1_oe", 64'(rom_oe), 64'd1);
        check("c1_cs", 64'(rom_cs), 64'd1);
        check("c1_a", 64'(rom_a), 64'h004);
        check("c1_rvalid", 64'(axi_if.RVALID_S), 64'd0);
        check("c1_arready", 64'(axi_if.ARREADY_S), 64'd0);
        check("c1_state", 64'(dbg_state), 64'd1);
        collect(8'h11, 2'b00, 1'b0, first);
        check("first_beat_cycle", 64'(first), 64'd1);
        check_addrs("single_a");

        // INCR across the top of the ROM
        start_burst();
        exp_q = '{32'hC0DE_0FFE, 32'hC0DE_0FFF, 32'hC0DE_0000, 32'hC0DE_0001};
        exp_a_q = '{12'hFFE, 12'hFFF, 12'h000, 12'h001};
        send_ar(8'h22, 32'h0000_3FF8, 4'd3, 3'd2, 2'b01);
        collect(8'h22, 2'b00, 1'b0, first);
        check_addrs("incr_a");

        // WRAP 4 beats at 0x18
        start_burst();
        exp_q = '{32'hC0DE_0006, 32'hC0DE_0007, 32'hC0DE_0004, 32'hC0DE_0005};
        exp_a_q = '{12'h006, 12'h007, 12'h004, 12'h005};
        send_ar(8'h33, 32'h0000_0018, 4'd3, 3'd2, 2'b10);
        collect(8'h33, 2'b00, 1'b0, first);
        check_addrs("wrap_a");

        // FIXED 3 beats at 0x20
        start_burst();
        exp_q = '{32'hC0DE_0008, 32'hC0DE_0008, 32'hC0DE_0008};
        exp_a_q = '{12'h008, 12'h008, 12'h008};
        send_ar(8'h44, 32'h0000_0020, 4'd2, 3'd2, 2'b00);
        collect(8'h44, 2'b00, 1'b0, first);
        check_addrs("fixed_a");

        // INCR with RREADY pattern 1,0,0,1,...
        start_burst();
        exp_q = '{32'hC0DE_0040, 32'hC0DE_0041, 32'hC0DE_0042, 32'hC0DE_0043};
        exp_a_q = '{12'h040, 12'h041, 12'h042, 12'h043};
        send_ar(8'h55, 32'h8000_0100, 4'd3, 3'd2, 2'b01);
        collect(8'h55, 2'b00, 1'b1, first);
        check_addrs("bp_a");

        // wrong size -> 3 SLVERR beats, no ROM access
        start_burst();
        exp_q = '{32'h0, 32'h0, 32'h0};
        send_ar(8'h66, 32'h0000_0040, 4'd2, 3'd1, 2'b01);
        collect(8'h66, 2'b10, 1'b1, first);
        check_addrs("err_size_a");

        // WRAP of 3 beats -> SLVERR
        start_burst();
        exp_q = '{32'h0, 32'h0, 32'h0};
        send_ar(8'h77, 32'h0000_0040, 4'd2, 3'd2, 2'b10);
        collect(8'h77, 2'b10, 1'b0, first);
        check_addrs("err_wrap_a");

        // reserved burst type -> SLVERR
        start_burst();
        exp_q = '{32'h0};
        send_ar(8'h88, 32'h0000_0040, 4'd0, 3'd2, 2'b11);
        collect(8'h88, 2'b10, 1'b0, first);
        check_addrs("err_burst_a");

        // reset during beat 2 of an 8-beat burst
        start_burst();
        send_ar(8'h99, 32'h0000_0200, 4'd7, 3'd2, 2'b01);
        axi_if.RREADY_S = 1'b1;
        @(negedge clk);
        #1;
        check("mid_beat1", 64'(axi_if.RDATA_S), 64'hC0DE_0080);
        @(negedge clk);
        #1;
        check("mid_beat2_valid", 64'(axi_if.RVALID_S), 64'd1);
        check("mid_beat2", 64'(axi_if.RDATA_S), 64'hC0DE_0081);
        rst = 1'b1;
        #1;
        check("mid_rst_rvalid", 64'(axi_if.RVALID_S), 64'd0);
        check("mid_rst_rdata", 64'(axi_if.RDATA_S), 64'd0);
        check("mid_rst_rlast", 64'(axi_if.RLAST_S), 64'd0);
        check("mid_rst_rid", 64'(axi_if.RID_S), 64'd0);
        check("mid_rst_oe", 64'(rom_oe), 64'd0);
        check("mid_rst_a", 64'(rom_a), 64'd0);
        check("mid_rst_arready", 64'(axi_if.ARREADY_S), 64'd0);
        axi_if.RREADY_S = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            #1;
            check("post_rst_quiet", 64'(axi_if.RVALID_S), 64'd0);
        end
        start_burst();
        exp_q.push_back(32'hC0DE_0002);
        exp_a_q.push_back(12'h002);
        send_ar(8'h5A, 32'h0000_0008, 4'd0, 3'd2, 2'b01);
        collect(8'h5A, 2'b00, 1'b0, first);
        check_addrs("post_rst_a");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/axi_rom_burst_slave.md
Name: axi_rom_burst_slave

Overview:
- Parametrised AXI4 read-only slave that fronts a synchronous single-port ROM macro (1-cycle read latency).
- Supports INCR, FIXED and WRAP bursts of any length up to 2^LEN_W beats, with full R-channel backpressure.
- Sustains one beat per cycle and returns SLVERR for illegal requests.
- Drop-in successor for ROM/boot-memory slave ports behind the AXI interconnect.

Parameters:
ID_W, 8, AXI ID width
ADDR_W, 32, AXI address width
DATA_W, 32, data width in bits (power of two, >=32)
ROM_AW, 12, ROM word-address width (depth = 2^ROM_AW words)
LEN_W, 4, ARLEN width (max burst = 2^LEN_W beats)

Ports:
ACLK  in  1  clock
ARESET  in  1  asynchronous active-high reset
ARID_S  in  ID_W  read ID
ARADDR_S  in  ADDR_W  byte start address
ARLEN_S  in  LEN_W  beats-1
ARSIZE_S  in  3  bytes per beat (log2)
ARBURST_S  in  2  00 FIXED, 01 INCR, 10 WRAP, 11 reserved
ARVALID_S  in  1  address valid
ARREADY_S  out  1  address ready
RID_S  out  ID_W  read ID
RDATA_S  out  DATA_W  read data (registered)
RRESP_S  out  2  00 OKAY, 10 SLVERR
RLAST_S  out  1  last beat
RVALID_S  out  1  data valid
RREADY_S  in  1  data ready
DO  in  DATA_W  ROM data, valid the cycle after A/OE
OE  out  1  ROM read enable
CS  out  1  ROM chip select (equal to OE)
A  out  ROM_AW  ROM word address

Behaviour:
- Reset: asynchronous, active-high. While ARESET=1 and after release: state IDLE; ARREADY_S=0 while asserted, 1 from the first clock after release; RVALID_S, RLAST_S, OE, CS=0; RID_S, RDATA_S, RRESP_S, A=0. Reset mid-burst abandons the burst; no further beats.
- OFF = log2(DATA_W/8). Start word = ARADDR_S[ROM_AW+OFF-1:OFF]. Higher address bits are ignored (interconnect decodes base).
- States: IDLE, FETCH, DATA, ERR.
- IDLE: ARREADY_S=1. On ARVALID_S, latch ID, word address, beat counter=ARLEN_S, and burst type.
  - Request legal -> FETCH.
  - Otherwise -> ERR.
- Illegal request: ARSIZE_S != OFF; ARBURST_S=11; or WRAP with ARLEN_S not in {1,3,7,15} (truncated to LEN_W).
- FETCH (1 cycle): A=current word, OE=CS=1. Next cycle RDATA_S<=DO, RVALID_S=1, RRESP_S=00, RLAST_S=(counter==0) -> DATA.
- DATA: RVALID_S, RDATA_S, RID_S, RLAST_S held stable while RREADY_S=0, with OE=0.
  - On RVALID_S&RREADY_S with RLAST_S=1: -> IDLE, RVALID_S deasserts next cycle.
  - On RVALID_S&RREADY_S with RLAST_S=0: in the same cycle A=next word and OE=1. Next cycle RDATA_S<=DO and the counter decrements. Sustains 1 beat/cycle.
- Next word:
  - INCR: +1, modulo 2^ROM_AW (wraps at ROM end).
  - FIXED: unchanged.
  - WRAP: low log2(len+1) bits increment modulo len+1; upper bits fixed.
- ERR: emit ARLEN_S+1 beats with RDATA_S=0, RRESP_S=10, correct RID_S and RLAST_S, honouring RREADY_S. OE=0 throughout. -> IDLE after last handshake.
- Latency: AR handshake cycle 0 -> A/OE cycle 1 -> first RVALID_S cycle 2.
- ARREADY_S=0 from cycle 1 until back in IDLE. No outstanding transactions (one burst at a time).
- RDATA_S never changes while RVALID_S=1 and RREADY_S=0.

Test Plan:
- Single beat: ARADDR=0x10, LEN=0, SIZE=2, INCR -> A=4 with OE in cycle 1; RVALID cycle 2, RDATA=ROM[4], RLAST=1, RRESP=00, ARREADY back to 1 cycle 3.
- INCR LEN=3 from 0x3FF8, RREADY held 1 -> A=0xFFE, 0xFFF, 0x000, 0x001 on consecutive cycles; four back-to-back beats, RLAST on the 4th.
- WRAP LEN=3 at 0x18 -> words 6, 7, 4, 5. FIXED LEN=2 at 0x20 -> word 8 three times.
- Backpressure: INCR LEN=3, RREADY toggling 1,0,0,1,... -> RDATA/RLAST stable during stalls, OE=0 during stalls, data order intact, no lost or duplicated beats.
- Errors: SIZE=1, LEN=2 -> 3 beats RRESP=10, RDATA=0, OE never asserted. WRAP LEN=2 -> SLVERR. BURST=11 -> SLVERR.
- Reset mid-burst: assert ARESET during beat 2 of a LEN=7 burst -> outputs zero immediately. After release, the next request ID=0x5A is served correctly with RID=0x5A.
